// File: rtl/pll_reconfig_ctrl_if.sv
// rtl/pll_reconfig_ctrl_if.sv - profile-change request handshake between requester and pll_reconfig_ctrl
interface pll_reconfig_ctrl_if;
    logic       req_valid;
    logic [1:0] req_profile;
    logic       req_ready;

    modport master (output req_valid, output req_profile, input req_ready);
    modport slave  (input req_valid, input req_profile, output req_ready);
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - rPLL profile reconfiguration and lock supervision FSM; PLL_LOCK_WATCH_EN enables loss-of-lock handling in RUN
module pll_reconfig_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3,
    parameter int INIT_PROFILE  = 0
) (
    input  logic                clk,
    input  logic                resetn,
    pll_reconfig_ctrl_if.slave  req,
    input  logic                pll_lock,
    output logic                pll_reset,
    output logic [5:0]          pll_idsel,
    output logic [5:0]          pll_fbdsel,
    output logic [5:0]          pll_odsel,
    output logic                dom_resetn,
    output logic [1:0]          cur_profile,
    output logic                busy,
    output logic                err
);

    localparam int RC_W = $clog2(RST_CYCLES + 2);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 2);
    localparam int SC_W = $clog2(STABLE_CYCLES + 2);
    localparam int RT_W = $clog2(MAX_RETRY + 2);
    localparam logic [1:0] INIT_P = 2'(INIT_PROFILE);

    // Returns {idsel, fbdsel, odsel}; odsel is 64 - ODIV/2, taken modulo 64 from the halved divider.
    function automatic logic [17:0] sel_codes(input logic [1:0] p);
        logic [5:0] idiv;
        logic [5:0] fbdiv;
        logic [5:0] ohalf;
        idiv  = 6'd0;
        fbdiv = 6'd2;
        ohalf = 6'd4;
        case (p)
            2'd0:    begin idiv = 6'd0; fbdiv = 6'd2;  ohalf = 6'd4;  end
            2'd1:    begin idiv = 6'd8; fbdiv = 6'd16; ohalf = 6'd4;  end
            2'd2:    begin idiv = 6'd3; fbdiv = 6'd10; ohalf = 6'd4;  end
            default: begin idiv = 6'd7; fbdiv = 6'd2;  ohalf = 6'd24; end
        endcase
        return {~idiv, ~fbdiv, 6'd0 - ohalf};
    endfunction

    localparam logic [17:0] INIT_CODES = sel_codes(INIT_P);

    typedef enum logic [2:0] {
        S_APPLY, S_RST_HOLD, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAIL
    } state_t;

    state_t          state;
    logic [1:0]      target;
    logic [1:0]      lock_sync;
    logic [RC_W-1:0] rst_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [SC_W-1:0] stab_cnt;
    logic [RT_W-1:0] retries;
    logic            lock_s;

    assign lock_s = lock_sync[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_APPLY;
            target        <= INIT_P;
            cur_profile   <= INIT_P;
            {pll_idsel, pll_fbdsel, pll_odsel} <= INIT_CODES;
            pll_reset     <= 1'b1;
            dom_resetn    <= 1'b0;
            busy          <= 1'b1;
            err           <= 1'b0;
            req.req_ready <= 1'b0;
            rst_cnt       <= '0;
            to_cnt        <= '0;
            stab_cnt      <= '0;
            retries       <= '0;
            lock_sync     <= '0;
        end else begin
            lock_sync <= {lock_sync[0], pll_lock};
            case (state)
                S_APPLY: begin
                    {pll_idsel, pll_fbdsel, pll_odsel} <= sel_codes(target);
                    cur_profile <= target;
                    pll_reset   <= 1'b1;
                    dom_resetn  <= 1'b0;
                    rst_cnt     <= '0;
                    state       <= S_RST_HOLD;
                end
                S_RST_HOLD: begin
                    if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        pll_reset <= 1'b0;
                        to_cnt    <= '0;
                        state     <= S_WAIT_LOCK;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        if (STABLE_CYCLES <= 1) begin
                            state         <= S_RUN;
                            dom_resetn    <= 1'b1;
                            busy          <= 1'b0;
                            req.req_ready <= 1'b1;
                            retries       <= '0;
                        end else begin
                            stab_cnt <= SC_W'(1);
                            state    <= S_STABLE;
                        end
                    end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
                        pll_reset <= 1'b1;
                        if (retries < RT_W'(MAX_RETRY)) begin
                            retries <= retries + RT_W'(1);
                            state   <= S_APPLY;
                        end else begin
                            state         <= S_FAIL;
                            busy          <= 1'b0;
                            err           <= 1'b1;
                            req.req_ready <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_STABLE: begin
                    // Timeout counter is frozen here so a lock glitch resumes the same budget.
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                    end else if (stab_cnt == SC_W'(STABLE_CYCLES - 1)) begin
                        state         <= S_RUN;
                        dom_resetn    <= 1'b1;
                        busy          <= 1'b0;
                        req.req_ready <= 1'b1;
                        retries       <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + SC_W'(1);
                    end
                end
                S_RUN, S_FAIL: begin
                    if (req.req_valid && req.req_ready) begin
                        target        <= req.req_profile;
                        retries       <= '0;
                        state         <= S_APPLY;
                        pll_reset     <= 1'b1;
                        dom_resetn    <= 1'b0;
                        busy          <= 1'b1;
                        err           <= 1'b0;
                        req.req_ready <= 1'b0;
                    end
`ifdef PLL_LOCK_WATCH_EN
                    else if (state == S_RUN && !lock_s) begin
                        state         <= S_WAIT_LOCK;
                        dom_resetn    <= 1'b0;
                        to_cnt        <= '0;
                        busy          <= 1'b1;
                        req.req_ready <= 1'b0;
                    end
`endif
                end
                default: begin
                    state <= S_APPLY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - randomized self-checking bench for pll_reconfig_ctrl
module tb_pll_reconfig_ctrl;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;
    localparam int HI_LEN        = RST_CYCLES + 1;
    localparam int LOCK_TO_RUN   = 2 + STABLE_CYCLES;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, dom_resetn, busy, err;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [1:0] cur_profile;

    pll_reconfig_ctrl_if rif ();

    pll_reconfig_ctrl #(
        .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRY(MAX_RETRY), .INIT_PROFILE(0)
    ) dut (
        .clk(clk), .resetn(resetn), .req(rif), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
        .pll_odsel(pll_odsel), .dom_resetn(dom_resetn), .cur_profile(cur_profile),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int idiv[4]  = '{0, 8, 3, 7};
    int fbdiv[4] = '{2, 16, 10, 2};
    int odiv[4]  = '{8, 8, 8, 48};
    int checks   = 0;
    int failures = 0;
    int exp_prof = 0;

    function automatic logic [17:0] exp_codes(input int p);
        int id, fb, od;
        id = 63 - idiv[p];
        fb = 63 - fbdiv[p];
        od = 64 - odiv[p] / 2;
        return {6'(id), 6'(fb), 6'(od)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_while(input logic lvl, output int n);
        n = 0;
        while (pll_reset === lvl && n < 1000) begin
            n++;
            tick();
        end
    endtask

    task automatic lock_after(input int delay, output int r, output bit clean);
        clean = 1'b1;
        repeat (delay) begin
            tick();
            if (pll_reset !== 1'b0 || dom_resetn !== 1'b0) clean = 1'b0;
        end
        pll_lock = 1'b1;
        r = 0;
        while (dom_resetn !== 1'b1 && r < 500) begin
            tick();
            r++;
            if (pll_reset !== 1'b0) clean = 1'b0;
        end
    endtask

    task automatic send_req(input int p);
        rif.req_valid   = 1'b1;
        rif.req_profile = 2'(p);
        pll_lock        = 1'b0;
        tick();
        rif.req_valid   = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rif.req_valid = 1'b0;
        rif.req_profile = 2'd0;
        repeat (3) tick();
        checks++;
        if ({pll_reset, dom_resetn, busy, err, rif.req_ready, cur_profile} !== 7'b1010000) begin
            failures++;
            $display("FAIL reset_ctrl got %b want %b",
                     {pll_reset, dom_resetn, busy, err, rif.req_ready, cur_profile}, 7'b1010000);
        end
        checks++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== exp_codes(0)) begin
            failures++;
            $display("FAIL reset_codes got %h want %h", {pll_idsel, pll_fbdsel, pll_odsel}, exp_codes(0));
        end
    endtask

    task automatic test_init_lock();
        int n, r;
        bit clean;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_prof = 0;
        count_while(1'b1, n);
        checks++;
        if (n != HI_LEN) begin
            failures++;
            $display("FAIL init_rst_len got %0d want %0d", n, HI_LEN);
        end
        checks++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'd63, 6'd61, 6'd60}) begin
            failures++;
            $display("FAIL init_codes got %h want %h", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd63, 6'd61, 6'd60});
        end
        lock_after(10, r, clean);
        checks++;
        if (r != LOCK_TO_RUN || !clean) begin
            failures++;
            $display("FAIL init_lock_to_run got %0d clean=%0d want %0d clean=1", r, clean, LOCK_TO_RUN);
        end
        checks++;
        if ({busy, rif.req_ready, err, cur_profile} !== 5'b01000) begin
            failures++;
            $display("FAIL init_run_flags got %b want %b", {busy, rif.req_ready, err, cur_profile}, 5'b01000);
        end
    endtask

    task automatic test_request();
        int p, n, r, d;
        bit clean;
        for (int i = 0; i < 6; i++) begin
            p = (i == 0) ? 3 : (i == 1) ? exp_prof : int'($urandom_range(0, 3));
            checks++;
            if (rif.req_ready !== 1'b1) begin
                failures++;
                $display("FAIL req_ready_run got %b want 1", rif.req_ready);
            end
            send_req(p);
            exp_prof = p;
            checks++;
            if ({dom_resetn, busy, rif.req_ready} !== 3'b010) begin
                failures++;
                $display("FAIL req_accept_flags p=%0d got %b want 010", p, {dom_resetn, busy, rif.req_ready});
            end
            count_while(1'b1, n);
            checks++;
            if (n != HI_LEN) begin
                failures++;
                $display("FAIL req_rst_len p=%0d got %0d want %0d", p, n, HI_LEN);
            end
            checks++;
            if ({pll_idsel, pll_fbdsel, pll_odsel, cur_profile} !== {exp_codes(p), 2'(p)}) begin
                failures++;
                $display("FAIL req_codes p=%0d got %h want %h", p,
                         {pll_idsel, pll_fbdsel, pll_odsel, cur_profile}, {exp_codes(p), 2'(p)});
            end
            d = int'($urandom_range(0, 60));
            lock_after(d, r, clean);
            checks++;
            if (r != LOCK_TO_RUN || !clean || busy !== 1'b0) begin
                failures++;
                $display("FAIL req_relock p=%0d got %0d clean=%0d busy=%b want %0d clean=1 busy=0",
                         p, r, clean, busy, LOCK_TO_RUN);
            end
        end
    endtask

    task automatic test_glitch();
        int p, n, r, k;
        bit clean;
        p = int'($urandom_range(0, 3));
        send_req(p);
        exp_prof = p;
        count_while(1'b1, n);
        repeat (int'($urandom_range(0, 30))) tick();
        pll_lock = 1'b1;
        k = int'($urandom_range(3, 6));
        repeat (k) tick();
        pll_lock = 1'b0;
        checks++;
        if (dom_resetn !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_early_run k=%0d got dom=%b busy=%b want dom=0 busy=1", k, dom_resetn, busy);
        end
        repeat (3) tick();
        lock_after(0, r, clean);
        checks++;
        if (r != LOCK_TO_RUN || !clean) begin
            failures++;
            $display("FAIL glitch_restart got %0d clean=%0d want %0d clean=1", r, clean, LOCK_TO_RUN);
        end
    endtask

    task automatic test_timeout();
        int p, n, r;
        int hi[3], lo[3];
        bit clean;
        p = int'($urandom_range(0, 3));
        send_req(p);
        for (int a = 0; a < MAX_RETRY + 1; a++) begin
            count_while(1'b1, hi[a]);
            count_while(1'b0, lo[a]);
            checks++;
            if (hi[a] != HI_LEN || lo[a] != LOCK_TIMEOUT) begin
                failures++;
                $display("FAIL timeout_attempt a=%0d got hi=%0d lo=%0d want hi=%0d lo=%0d",
                         a, hi[a], lo[a], HI_LEN, LOCK_TIMEOUT);
            end
        end
        checks++;
        if ({pll_reset, dom_resetn, busy, err, rif.req_ready} !== 5'b10011) begin
            failures++;
            $display("FAIL fail_entry got %b want 10011", {pll_reset, dom_resetn, busy, err, rif.req_ready});
        end
        repeat (20) tick();
        checks++;
        if ({pll_reset, err, rif.req_ready} !== 3'b111) begin
            failures++;
            $display("FAIL fail_hold got %b want 111", {pll_reset, err, rif.req_ready});
        end
        send_req(1);
        exp_prof = 1;
        checks++;
        if ({err, busy} !== 2'b01) begin
            failures++;
            $display("FAIL fail_clear got %b want 01", {err, busy});
        end
        count_while(1'b1, n);
        lock_after(int'($urandom_range(0, 40)), r, clean);
        checks++;
        if (n != HI_LEN || r != LOCK_TO_RUN || !clean || cur_profile !== 2'd1
            || {pll_idsel, pll_fbdsel, pll_odsel} !== exp_codes(1)) begin
            failures++;
            $display("FAIL fail_relock got hi=%0d r=%0d clean=%0d prof=%0d want hi=%0d r=%0d clean=1 prof=1",
                     n, r, clean, cur_profile, HI_LEN, LOCK_TO_RUN);
        end
    endtask

    task automatic test_lock_drop_run();
        logic [17:0] codes_before;
        int r;
        bit clean;
        codes_before = {pll_idsel, pll_fbdsel, pll_odsel};
        pll_lock = 1'b0;
        repeat (3) tick();
`ifdef PLL_LOCK_WATCH_EN
        checks++;
        if ({dom_resetn, busy, pll_reset} !== 3'b010) begin
            failures++;
            $display("FAIL watch_drop got %b want 010", {dom_resetn, busy, pll_reset});
        end
        lock_after(0, r, clean);
        checks++;
        if (r != LOCK_TO_RUN || !clean || {pll_idsel, pll_fbdsel, pll_odsel} !== codes_before) begin
            failures++;
            $display("FAIL watch_relock got %0d clean=%0d codes=%h want %0d clean=1 codes=%h",
                     r, clean, {pll_idsel, pll_fbdsel, pll_odsel}, LOCK_TO_RUN, codes_before);
        end
`else
        repeat (10) tick();
        checks++;
        if ({dom_resetn, busy, pll_reset} !== 3'b100 || {pll_idsel, pll_fbdsel, pll_odsel} !== codes_before) begin
            failures++;
            $display("FAIL nowatch_drop got %b want 100", {dom_resetn, busy, pll_reset});
        end
        lock_after(0, r, clean);
`endif
    endtask

    task automatic test_reset_midflight();
        int p, n, r;
        bit clean, ready_low;
        p = int'($urandom_range(0, 3));
        send_req(p);
        count_while(1'b1, n);
        repeat (5) tick();
        rif.req_valid   = 1'b1;
        rif.req_profile = 2'((p + 1) % 4);
        ready_low = 1'b1;
        repeat (5) begin
            tick();
            if (rif.req_ready !== 1'b0) ready_low = 1'b0;
        end
        checks++;
        if (!ready_low || cur_profile !== 2'(p)) begin
            failures++;
            $display("FAIL busy_ignore got ready_low=%0d prof=%0d want 1 prof=%0d", ready_low, cur_profile, p);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({pll_reset, dom_resetn, busy, err, rif.req_ready, cur_profile} !== 7'b1010000
            || {pll_idsel, pll_fbdsel, pll_odsel} !== exp_codes(0)) begin
            failures++;
            $display("FAIL async_reset got %b codes=%h want 1010000 codes=%h",
                     {pll_reset, dom_resetn, busy, err, rif.req_ready, cur_profile},
                     {pll_idsel, pll_fbdsel, pll_odsel}, exp_codes(0));
        end
        rif.req_valid = 1'b0;
        tick();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_prof = 0;
        count_while(1'b1, n);
        lock_after(int'($urandom_range(0, 40)), r, clean);
        checks++;
        if (n != HI_LEN || r != LOCK_TO_RUN || !clean || cur_profile !== 2'd0) begin
            failures++;
            $display("FAIL post_reset_relock got hi=%0d r=%0d clean=%0d prof=%0d want hi=%0d r=%0d clean=1 prof=0",
                     n, r, clean, cur_profile, HI_LEN, LOCK_TO_RUN);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init_lock();
        test_request();
        test_glitch();
        test_timeout();
        test_lock_drop_run();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
